// File: rtl/synapse_accumulator_if.sv
// Product-stream / sum-handshake bundle between the multiplier, the
// synapse accumulator and the downstream activation stage.
interface synapse_accumulator_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 32
) ();
  logic             Start;
  logic [IN_W-1:0]  ProductIn;
  logic             ProductValid;
  logic             Busy;
  logic [OUT_W-1:0] SumOut;
  logic             SumValid;
  logic             SumReady;
  logic             Overflow;

  // Driver side: issues Start, feeds products and accepts sums.
  modport master (
    output Start, ProductIn, ProductValid, SumReady,
    input  Busy, SumOut, SumValid, Overflow
  );

  // Accumulator side.
  modport slave (
    input  Start, ProductIn, ProductValid, SumReady,
    output Busy, SumOut, SumValid, Overflow
  );
endinterface

// File: rtl/synapse_accumulator.sv
// Sums NUM_TERMS signed products into one neuron pre-activation value and
// presents it, saturated to OUT_W bits, over a valid/ready handshake.
module synapse_accumulator #(
  parameter int IN_W      = 26,
  parameter int NUM_TERMS = 784,
  parameter int ACC_W     = 36,
  parameter int OUT_W     = 32
) (
  input  logic                  clk,
  input  logic                  GlobalReset,
  synapse_accumulator_if.slave  bus
);

  localparam int              CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   sum_q, sum_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               busy_q;

  logic [ACC_W-1:0]     acc_sum;
  logic [ACC_W-OUT_W:0] upper;
  logic                 clamp;
  logic [OUT_W-1:0]     sat_val;

  // Running sum including the product on the bus, and its OUT_W saturation.
  // The value fits OUT_W only when every bit from OUT_W-1 upward is a copy
  // of the sign bit; otherwise clamp toward the sign.
  always_comb begin
    acc_sum = acc_q + {{(ACC_W-IN_W){bus.ProductIn[IN_W-1]}}, bus.ProductIn};
    upper   = acc_sum[ACC_W-1:OUT_W-1];
    clamp   = !((upper == '0) || (upper == '1));
    if (!clamp)
      sat_val = acc_sum[OUT_W-1:0];
    else if (acc_sum[ACC_W-1])
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    else
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.ProductValid) begin
          acc_d = acc_sum;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            sum_d   = sat_val;
            valid_d = 1'b1;
            ovf_d   = clamp;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (valid_q && bus.SumReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; Busy is registered from the next state.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.SumOut   = sum_q;
  assign bus.SumValid = valid_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Randomised bench for synapse_accumulator with a 4-term, 26-bit-output build.
module tb_synapse_accumulator;

  localparam int IN_W  = 26;
  localparam int NT    = 4;
  localparam int ACC_W = 36;
  localparam int OUT_W = 26;
  localparam longint SMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (OUT_W - 1));

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   prod[NT];

  synapse_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  synapse_accumulator #(
    .IN_W(IN_W), .NUM_TERMS(NT), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .GlobalReset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sum_out();
    return longint'($signed(bus.SumOut));
  endfunction

  // Runs one complete sum of prod[] with 'gap' idle cycles between products
  // and 'hold' cycles of SumReady=0 once the result is presented.
  task automatic run_sum(input string tag, input int gap, input int hold);
    longint s;
    longint exp_out;
    longint exp_ovf;
    logic [IN_W-1:0] junk;
    s = 0;
    for (int i = 0; i < NT; i++) s += prod[i];
    if (s > SMAX) begin
      exp_out = SMAX; exp_ovf = 1;
    end else if (s < SMIN) begin
      exp_out = SMIN; exp_ovf = 1;
    end else begin
      exp_out = s; exp_ovf = 0;
    end

    // A product presented in IDLE must not count.
    junk = IN_W'($urandom);
    bus.Start = 1'b0; bus.ProductValid = 1'b1; bus.ProductIn = junk;
    tick();
    check({tag, ".idle_busy"}, longint'(bus.Busy), 0);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0; bus.ProductValid = 1'b0;
    check({tag, ".start_busy"}, longint'(bus.Busy), 1);
    bus.SumReady = (hold == 0);

    for (int i = 0; i < NT; i++) begin
      bus.ProductValid = 1'b1;
      bus.ProductIn    = prod[i][IN_W-1:0];
      tick();
      bus.ProductValid = 1'b0;
      junk = IN_W'($urandom);
      bus.ProductIn = junk;
      if (i < NT - 1) begin
        check({tag, ".early_valid"}, longint'(bus.SumValid), 0);
        for (int g = 0; g < gap; g++) begin
          tick();
          check({tag, ".gap_busy"}, longint'(bus.Busy), 1);
        end
      end
    end
    check({tag, ".valid"}, longint'(bus.SumValid), 1);
    check({tag, ".sum"}, sum_out(), exp_out);
    check({tag, ".ovf"}, longint'(bus.Overflow), exp_ovf);

    for (int h = 0; h < hold; h++) begin
      junk = IN_W'($urandom);
      bus.ProductValid = 1'b1; bus.ProductIn = junk; bus.Start = 1'b1;
      tick();
      check({tag, ".hold_valid"}, longint'(bus.SumValid), 1);
      check({tag, ".hold_sum"}, sum_out(), exp_out);
      check({tag, ".hold_ovf"}, longint'(bus.Overflow), exp_ovf);
    end
    // Start asserted during the accepting cycle must be ignored.
    bus.ProductValid = 1'b0; bus.SumReady = 1'b1; bus.Start = 1'b1;
    tick();
    check({tag, ".ack_valid"}, longint'(bus.SumValid), 0);
    check({tag, ".ack_busy"}, longint'(bus.Busy), 0);
    bus.Start = 1'b0;
    tick();
    check({tag, ".post_idle"}, longint'(bus.Busy), 0);
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    prod[0] = a; prod[1] = b; prod[2] = c; prod[3] = d;
  endtask

  initial begin
    logic [IN_W-1:0] r;
    n_tests = 0;
    n_fail  = 0;
    bus.Start = 1'b1; bus.ProductValid = 1'b0; bus.ProductIn = '0; bus.SumReady = 1'b1;
    rst_n = 1'b0;

    // Reset with Start held high.
    tick(); tick();
    check("rst.valid", longint'(bus.SumValid), 0);
    check("rst.busy", longint'(bus.Busy), 0);
    check("rst.sum", sum_out(), 0);
    check("rst.ovf", longint'(bus.Overflow), 0);
    bus.Start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst.after_busy", longint'(bus.Busy), 0);

    set4(0, 50, 400, 2000);          run_sum("basic", 0, 0);
    set4(-100, 25, -3, 7);           run_sum("signed_gap", 3, 0);
    set4(33554431, 33554431, 33554431, 33554431); run_sum("sat_pos", 0, 0);
    set4(-33554432, -33554432, -33554432, -33554432); run_sum("sat_neg", 0, 0);
    set4(33554431, 0, 0, 0);         run_sum("edge_max", 0, 0);
    set4(-33554432, 0, 0, 0);        run_sum("edge_min", 1, 0);
    set4(33554431, 1, 0, 0);         run_sum("edge_max1", 0, 0);
    set4(0, 50, 400, 2000);          run_sum("backpressure", 0, 5);

    // Reset in the middle of a sum discards it.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ProductValid = 1'b1; bus.ProductIn = IN_W'(1000);
      tick();
    end
    bus.ProductValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst.busy", longint'(bus.Busy), 0);
    check("midrst.valid", longint'(bus.SumValid), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("midrst.idle", longint'(bus.Busy), 0);
    set4(1, 1, 1, 1);                run_sum("after_rst", 0, 0);

    // Random full-range and small-range products with random gaps and stalls.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NT; i++) begin
        r = IN_W'($urandom);
        if (t % 2 == 0) prod[i] = int'($signed(r));
        else            prod[i] = int'($urandom_range(0, 4000)) - 2000;
      end
      run_sum("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
